// File: rtl/argmax_stream_if.sv
// Stream bundle for the argmax classifier head.
//   input_valid/input_ready/input_data : M-beat activation vector, one element per beat
//   output_valid/output_ready          : single result beat per vector
//   output_index/output_max            : position and value of the largest element
// slave  = argmax_stream side, master = upstream/downstream (testbench) side.
interface argmax_stream_if #(
    parameter int M = 4,
    parameter int T = 12
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic                 input_valid;
    logic                 input_ready;
    logic signed [T-1:0]  input_data;
    logic                 output_valid;
    logic                 output_ready;
    logic [IW-1:0]        output_index;
    logic signed [T-1:0]  output_max;

    modport slave (
        input  input_valid, input_data, output_ready,
        output input_ready, output_valid, output_index, output_max
    );

    modport master (
        output input_valid, input_data, output_ready,
        input  input_ready, output_valid, output_index, output_max
    );
endinterface

// File: rtl/argmax_stream.sv
// Streaming argmax: consumes an M-element vector of signed T-bit activations,
// one beat per accepted handshake, and emits the index and value of the
// largest element as one registered result beat.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   s     : argmax_stream_if slave (input stream in, result stream out)
module argmax_stream #(
    parameter int M = 4,
    parameter int T = 12
) (
    input  logic           clk,
    input  logic           reset,
    argmax_stream_if.slave s
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       cnt_q, cnt_d;
    logic signed [T-1:0] best_val_q, best_val_d;
    logic [IW-1:0]       best_idx_q, best_idx_d;
    logic signed [T-1:0] out_max_q, out_max_d;
    logic [IW-1:0]       out_idx_q, out_idx_d;

    logic accept, last, take;

    // Ready depends only on state; reset forces it low so nothing is taken
    // while the stage is being cleared.
    assign s.input_ready  = (state_q == ACCUM) && !reset;
    assign s.output_valid = (state_q == HOLD);
    assign s.output_index = out_idx_q;
    assign s.output_max   = out_max_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        out_max_d  = out_max_q;
        out_idx_d  = out_idx_q;

        accept = s.input_valid && s.input_ready;
        last   = (cnt_q == IW'(M - 1));
        // Element 0 always seeds the running best; later elements need a
        // strictly greater value so ties keep the lower index.
        take   = (cnt_q == '0) || (s.input_data > best_val_q);

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (take) begin
                        best_val_d = s.input_data;
                        best_idx_d = cnt_q;
                    end
                    if (last) begin
                        // Fold the last beat's compare straight into the result.
                        out_max_d = take ? s.input_data : best_val_q;
                        out_idx_d = take ? cnt_q : best_idx_q;
                        cnt_d     = '0;
                        state_d   = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (s.output_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            out_max_q  <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            out_max_q  <= out_max_d;
            out_idx_q  <= out_idx_d;
        end
    end
endmodule

// File: tb/tb_argmax_stream.sv
// Testbench for argmax_stream: directed vector table, multi-cycle corner
// sequences and a randomized run, all checked through a result scoreboard.
module tb_argmax_stream;
    localparam int M  = 4;
    localparam int T  = 12;

    typedef logic signed [T-1:0] vec_t [M];
    typedef struct {
        vec_t d;
        int   bub;   // idle cycles inserted before each beat
        int   ei;
        int   em;
    } tv_t;
    typedef struct {
        int idx;
        int max;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    bit   rand_rdy = 1'b0;
    res_t sb [$];

    argmax_stream_if #(.M(M), .T(T)) ifc ();
    argmax_stream #(.M(M), .T(T)) dut (.clk(clk), .reset(reset), .s(ifc.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Scoreboard: every result transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && ifc.output_valid && ifc.output_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got idx %0d max %0d expected none",
                         ifc.output_index, $signed(ifc.output_max));
            end else begin
                res_t e;
                e = sb.pop_front();
                check("result_idx", int'(ifc.output_index), e.idx);
                check("result_max", int'($signed(ifc.output_max)), e.max);
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 ifc.output_ready = 1'($urandom_range(1));
        end
    end

    function automatic res_t ref_argmax(input vec_t v);
        res_t r;
        r.idx = 0;
        r.max = int'(v[0]);
        for (int i = 1; i < M; i++)
            if (int'(v[i]) > r.max) begin
                r.max = int'(v[i]);
                r.idx = i;
            end
        return r;
    endfunction

    task automatic push(input int idx, input int mx);
        res_t r;
        r.idx = idx;
        r.max = mx;
        sb.push_back(r);
    endtask

    // Drive one vector; returns at posedge+1 after the edge that took the last beat.
    task automatic send_vec(input vec_t v, input int bub);
        for (int i = 0; i < M; i++) begin
            bit acc;
            int guard;
            acc = 1'b0;
            guard = 0;
            for (int b = 0; b < bub; b++) begin
                ifc.input_valid = 1'b0;
                @(posedge clk); #1;
            end
            while (!acc) begin
                ifc.input_valid = 1'b1;
                ifc.input_data  = v[i];
                @(negedge clk);
                acc = ifc.input_valid && ifc.input_ready;
                @(posedge clk); #1;
                guard++;
                if (guard > 500) begin
                    $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", i, guard);
                    $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
                    $fatal(1, "stuck");
                end
            end
        end
        ifc.input_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_remaining", sb.size(), 0);
        sb.delete();
    endtask

    tv_t  tbl [4];
    vec_t v;
    res_t r;

    initial begin
        tbl[0].d = '{-12'sd31, 12'sd5, 12'sd5, 12'sh800};          tbl[0].bub = 0; tbl[0].ei = 1; tbl[0].em = 5;
        tbl[1].d = '{12'sh800, 12'sh800, 12'sh800, 12'sh800};      tbl[1].bub = 0; tbl[1].ei = 0; tbl[1].em = -2048;
        tbl[2].d = '{-12'sd1, -12'sd2, 12'sd2047, 12'sd2047};      tbl[2].bub = 0; tbl[2].ei = 2; tbl[2].em = 2047;
        tbl[3].d = '{12'sd3, 12'sd9, -12'sd4, 12'sd1};             tbl[3].bub = 2; tbl[3].ei = 1; tbl[3].em = 9;

        reset = 1'b1;
        ifc.input_valid  = 1'b0;
        ifc.input_data   = '0;
        ifc.output_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", int'(ifc.input_ready), 0);
        check("reset_out_valid", int'(ifc.output_valid), 0);
        check("reset_out_index", int'(ifc.output_index), 0);
        check("reset_out_max", int'($signed(ifc.output_max)), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", int'(ifc.input_ready), 1);
        @(posedge clk); #1;

        // Directed table: latency and single-cycle output_valid on each entry.
        for (int t = 0; t < 4; t++) begin
            send_vec(tbl[t].d, tbl[t].bub);
            push(tbl[t].ei, tbl[t].em);
            @(negedge clk);
            check("latency_valid", int'(ifc.output_valid), 1);
            @(posedge clk); #1;
            @(negedge clk);
            check("valid_one_cycle", int'(ifc.output_valid), 0);
            check("ready_after_xfer", int'(ifc.input_ready), 1);
            @(posedge clk); #1;
        end
        drain(20);

        // Backpressure: result held stable, extra beat refused.
        ifc.output_ready = 1'b0;
        v = '{12'sd0, 12'sd0, 12'sd0, 12'sd7};
        send_vec(v, 0);
        push(3, 7);
        ifc.input_valid = 1'b1;
        ifc.input_data  = 12'sd55;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_valid", int'(ifc.output_valid), 1);
            check("stall_index", int'(ifc.output_index), 3);
            check("stall_max", int'($signed(ifc.output_max)), 7);
            check("stall_ready", int'(ifc.input_ready), 0);
            @(posedge clk); #1;
        end
        ifc.input_valid  = 1'b0;
        ifc.output_ready = 1'b1;
        @(negedge clk);
        check("release_valid", int'(ifc.output_valid), 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_ready", int'(ifc.input_ready), 1);
        check("release_valid_drop", int'(ifc.output_valid), 0);
        @(posedge clk); #1;
        drain(5);

        // A following vector proves the stalled beat was never consumed.
        v = '{12'sd1, 12'sd2, 12'sd3, 12'sd0};
        send_vec(v, 0);
        push(2, 3);
        drain(10);

        // Reset mid-vector: partial vector discarded, next beat is element 0.
        ifc.input_valid = 1'b1;
        ifc.input_data  = 12'sd100;
        @(posedge clk); #1;
        ifc.input_data  = 12'sd200;
        @(posedge clk); #1;
        ifc.input_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("midvec_ready_in_reset", int'(ifc.input_ready), 0);
        @(posedge clk); #1 reset = 1'b0;
        v = '{-12'sd5, -12'sd6, -12'sd7, -12'sd3};
        send_vec(v, 0);
        push(3, -3);
        drain(10);

        // Random vectors with random bubbles and output backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < M; i++) begin
                case ($urandom_range(2))
                    0: v[i] = T'($urandom);
                    1: v[i] = T'($signed($urandom_range(4)) - 2);
                    default: v[i] = $urandom_range(1) ? 12'sd2047 : 12'sh800;
                endcase
            end
            send_vec(v, $urandom_range(2) == 0 ? 1 : 0);
            r = ref_argmax(v);
            push(r.idx, r.max);
        end
        rand_rdy = 1'b0;
        @(posedge clk); #1 ifc.output_ready = 1'b1;
        drain(50);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
